soundweb_decoder: RTL
=====================

SOUNDWEB_DECODER -- requirements
Module: soundweb_decoder

Interface
REQ-001 SHALL have parameter STX, default 8'h02, start-of-frame byte.
REQ-002 SHALL have parameter ETX, default 8'h03, end-of-frame byte.
REQ-003 SHALL have parameter ESC, default 8'h1B, escape prefix byte.
REQ-004 SHALL have parameter ACK, default 8'h06, and parameter NAK, default 8'h15, single-byte handshake codes.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port rx_data, input, 8, received byte from UART.
REQ-008 SHALL have port rx_valid, input, 1, rx_data valid this cycle; no backpressure, one byte accepted per valid cycle.
REQ-009 SHALL have ports command, address_0..address_5, sv_0, sv_1, data_0..data_3, output, 8 each, fields of last good frame.
REQ-010 SHALL have port frame_valid, output, 1, one-cycle pulse when a good frame is latched.
REQ-011 SHALL have port frame_error, output, 1, one-cycle pulse on any malformed frame.
REQ-012 SHALL have ports ack_rx and nak_rx, output, 1 each, one-cycle pulses on ACK/NAK received outside a frame.

Function
REQ-013 Frame format SHALL be: STX, 13 body bytes (command, address_0..5, sv_0, sv_1, data_0..3), 1 checksum byte, ETX; body and checksum escaped on the wire.
REQ-014 Reserved bytes SHALL be STX, ETX, ACK, NAK, ESC; on the wire each appears as ESC followed by (byte + 8'h80).
REQ-015 Checksum SHALL be the 8-bit XOR of the 13 unescaped body bytes.
REQ-016 States SHALL be IDLE, RECV, ESCAPE.
REQ-017 IDLE: STX -> RECV, clear byte count (4 bits) and running XOR; ACK -> ack_rx pulse; NAK -> nak_rx pulse; all other bytes ignored.
REQ-018 RECV: ESC -> ESCAPE; STX -> restart (count/XOR cleared, stay RECV), no error pulse; ETX with count==14 -> checksum compare, IDLE; ETX with count<14 -> frame_error, IDLE; any other byte with count<14 -> store at index count, count+1; any non-ETX byte with count==14 -> frame_error, IDLE.
REQ-019 ESCAPE: byte in {8'h82, 8'h83, 8'h86, 8'h95, 8'h9B} -> unescaped value (byte - 8'h80) stored as in RECV, return RECV; any other byte, or count==14 -> frame_error, IDLE.
REQ-020 Count index 0..12 SHALL write body shadow registers; index 13 SHALL be the received checksum and SHALL NOT enter the running XOR.
REQ-021 On ETX with count==14 and received checksum == running XOR, the field outputs SHALL update from shadow registers and frame_valid SHALL pulse, both on the clock edge following the cycle in which ETX is accepted (1-cycle latency).
REQ-022 On checksum mismatch, frame_error SHALL pulse with the same timing; field outputs SHALL NOT change.
REQ-023 Field outputs SHALL change only on a good frame; partial or bad frames SHALL never be visible.
REQ-024 Cycles with rx_valid low SHALL not change state, count or XOR; bytes need not be consecutive.
REQ-025 frame_valid, frame_error, ack_rx, nak_rx SHALL be mutually exclusive and never high for two consecutive cycles from one byte.
REQ-026 ACK/NAK inside RECV or ESCAPE unescaped SHALL cause frame_error and return to IDLE without ack_rx/nak_rx.

Reset
REQ-027 Reset SHALL force IDLE, count 0, XOR 0, all field outputs 8'h00, all pulse outputs 0, immediately and asynchronously.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the decoder SHALL require a fresh STX.

Verification
REQ-029 Stream 02 88 00 01 1B 83 00 01 00 00 01 00 00 00 64 EE 03 -> frame_valid once; command 88, address 00 01 03 00 01 00, sv 00 01, data 00 00 00 64.
REQ-030 Same stream with checksum EF -> frame_error once; fields hold previous values, frame_valid stays 0.
REQ-031 Stream 02 88 00 1B 41 ... -> frame_error on 41, then 06 -> ack_rx pulse (back in IDLE).
REQ-032 Stream 02 88 00 01 02 followed by a full valid frame body -> no error; only the second frame decoded.
REQ-033 Valid frame with rx_valid low for 3 cycles between every byte -> identical result to REQ-029.
REQ-034 Reset pulse after 8 body bytes, then valid frame -> only that frame decoded; outputs 00 before it.

Source files
------------

// File: rtl/soundweb_decoder_if.sv
// rtl/soundweb_decoder_if.sv - byte stream in, decoded frame fields and event pulses out
//
// Signals:
//   rx_data/rx_valid      : received UART byte, one accepted per valid cycle
//   command .. data_3     : fields of the last good frame
//   frame_valid           : one-cycle pulse when a good frame is latched
//   frame_error           : one-cycle pulse on a malformed frame
//   ack_rx/nak_rx         : one-cycle pulses on ACK/NAK received outside a frame
// Modports: master drives the byte stream, slave is the decoder.
interface soundweb_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] command;
    logic [7:0] address_0;
    logic [7:0] address_1;
    logic [7:0] address_2;
    logic [7:0] address_3;
    logic [7:0] address_4;
    logic [7:0] address_5;
    logic [7:0] sv_0;
    logic [7:0] sv_1;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [7:0] data_2;
    logic [7:0] data_3;
    logic       frame_valid;
    logic       frame_error;
    logic       ack_rx;
    logic       nak_rx;

    modport master (
        output rx_data, rx_valid,
        input  command, address_0, address_1, address_2, address_3, address_4, address_5,
        input  sv_0, sv_1, data_0, data_1, data_2, data_3,
        input  frame_valid, frame_error, ack_rx, nak_rx
    );

    modport slave (
        input  rx_data, rx_valid,
        output command, address_0, address_1, address_2, address_3, address_4, address_5,
        output sv_0, sv_1, data_0, data_1, data_2, data_3,
        output frame_valid, frame_error, ack_rx, nak_rx
    );
endinterface

// File: rtl/soundweb_decoder.sv
// rtl/soundweb_decoder.sv - escaped, XOR-checksummed frame decoder for a UART byte stream
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : soundweb_decoder_if.slave (byte stream in, fields and pulses out)
//
// Every byte that produces an event (good frame, error, ACK, NAK) records it
// in a pending register; the pulse is emitted on the following edge. Giving
// all events the same one-cycle latency keeps the four pulses mutually
// exclusive even when an event-producing byte follows ETX back to back.
module soundweb_decoder #(
    parameter logic [7:0] STX = 8'h02,
    parameter logic [7:0] ETX = 8'h03,
    parameter logic [7:0] ESC = 8'h1B,
    parameter logic [7:0] ACK = 8'h06,
    parameter logic [7:0] NAK = 8'h15
) (
    input  logic               clk,
    input  logic               reset,
    soundweb_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RECV, ESCAPE} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_CHECK, EV_ERROR, EV_ACK, EV_NAK} event_t;

    localparam logic [3:0] BODY_LEN  = 4'd13;
    localparam logic [3:0] FRAME_LEN = 4'd14;   // body plus checksum

    state_t     state;
    event_t     pend;
    logic [3:0] count;
    logic [7:0] xor_acc;
    logic [7:0] rx_csum;
    logic [7:0] shadow [13];
    logic [7:0] field_q [13];
    logic       frame_valid_q;
    logic       frame_error_q;
    logic       ack_rx_q;
    logic       nak_rx_q;

    logic [7:0] unesc;
    logic       esc_ok;
    logic [7:0] store_val;

    always_comb begin
        unesc     = bus.rx_data - 8'h80;
        esc_ok    = (unesc == STX) || (unesc == ETX) || (unesc == ACK) ||
                    (unesc == NAK) || (unesc == ESC);
        store_val = (state == ESCAPE) ? unesc : bus.rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pend          <= EV_NONE;
            count         <= 4'd0;
            xor_acc       <= 8'h00;
            rx_csum       <= 8'h00;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            ack_rx_q      <= 1'b0;
            nak_rx_q      <= 1'b0;
            for (int i = 0; i < 13; i++) begin
                shadow[i]  <= 8'h00;
                field_q[i] <= 8'h00;
            end
        end else begin
            // Emit the event recorded on the previous accepted byte.
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            ack_rx_q      <= 1'b0;
            nak_rx_q      <= 1'b0;
            case (pend)
                EV_CHECK: begin
                    // shadow/xor_acc/rx_csum still hold the completed frame here;
                    // a byte accepted on this same edge only updates them afterwards.
                    if (rx_csum == xor_acc) begin
                        frame_valid_q <= 1'b1;
                        for (int i = 0; i < 13; i++) field_q[i] <= shadow[i];
                    end else begin
                        frame_error_q <= 1'b1;
                    end
                end
                EV_ERROR: frame_error_q <= 1'b1;
                EV_ACK:   ack_rx_q      <= 1'b1;
                EV_NAK:   nak_rx_q      <= 1'b1;
                default:  ;
            endcase
            pend <= EV_NONE;

            if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.rx_data == STX) begin
                            state   <= RECV;
                            count   <= 4'd0;
                            xor_acc <= 8'h00;
                        end else if (bus.rx_data == ACK) begin
                            pend <= EV_ACK;
                        end else if (bus.rx_data == NAK) begin
                            pend <= EV_NAK;
                        end
                    end
                    RECV: begin
                        if (bus.rx_data == ESC) begin
                            state <= ESCAPE;
                        end else if (bus.rx_data == STX) begin
                            count   <= 4'd0;
                            xor_acc <= 8'h00;
                        end else if (bus.rx_data == ETX) begin
                            pend  <= (count == FRAME_LEN) ? EV_CHECK : EV_ERROR;
                            state <= IDLE;
                        end else if ((bus.rx_data == ACK) || (bus.rx_data == NAK) ||
                                     (count == FRAME_LEN)) begin
                            pend  <= EV_ERROR;
                            state <= IDLE;
                        end else begin
                            if (count < BODY_LEN) begin
                                shadow[count] <= store_val;
                                xor_acc       <= xor_acc ^ store_val;
                            end else begin
                                rx_csum <= store_val;
                            end
                            count <= count + 4'd1;
                        end
                    end
                    ESCAPE: begin
                        if (!esc_ok || (count == FRAME_LEN)) begin
                            pend  <= EV_ERROR;
                            state <= IDLE;
                        end else begin
                            if (count < BODY_LEN) begin
                                shadow[count] <= store_val;
                                xor_acc       <= xor_acc ^ store_val;
                            end else begin
                                rx_csum <= store_val;
                            end
                            count <= count + 4'd1;
                            state <= RECV;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.command     = field_q[0];
    assign bus.address_0   = field_q[1];
    assign bus.address_1   = field_q[2];
    assign bus.address_2   = field_q[3];
    assign bus.address_3   = field_q[4];
    assign bus.address_4   = field_q[5];
    assign bus.address_5   = field_q[6];
    assign bus.sv_0        = field_q[7];
    assign bus.sv_1        = field_q[8];
    assign bus.data_0      = field_q[9];
    assign bus.data_1      = field_q[10];
    assign bus.data_2      = field_q[11];
    assign bus.data_3      = field_q[12];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.ack_rx      = ack_rx_q;
    assign bus.nak_rx      = nak_rx_q;
endmodule
